// File: rtl/instr_encoder.sv
// Encodes abstract instruction requests into 32-bit MIPS words through one registered output stage.
// Optional: define ENCODER_BRANCH_ABS_EN to treat the BEQ immediate as an absolute target word address.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_kind,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [15:0]           in_imm,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_word,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  err,
  output logic [3:0]            err_kind
);

  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [3:0] K_NOP  = 4'd0;
  localparam logic [3:0] K_ADD  = 4'd1;
  localparam logic [3:0] K_SUB  = 4'd2;
  localparam logic [3:0] K_AND  = 4'd3;
  localparam logic [3:0] K_OR   = 4'd4;
  localparam logic [3:0] K_SLT  = 4'd5;
  localparam logic [3:0] K_ADDI = 4'd6;
  localparam logic [3:0] K_LW   = 4'd7;
  localparam logic [3:0] K_SW   = 4'd8;
  localparam logic [3:0] K_BEQ  = 4'd9;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  logic                  r_out_valid;
  logic [31:0]           r_out_word;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic [3:0]            r_err_kind;

  logic                  w_accept;
  logic                  w_kind_ok;
  logic [ADDR_WIDTH-1:0] w_addr_eff;
  logic                  w_err_eff;
  logic [15:0]           w_beq_imm;
  logic [31:0]           w_word;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_kind_ok  = (in_kind <= K_BEQ);
  // clr takes effect before a request accepted on the same edge
  assign w_addr_eff = clr ? LP_BASE : r_addr;
  assign w_err_eff  = clr ? 1'b0 : r_err;

`ifdef ENCODER_BRANCH_ABS_EN
  logic [15:0] w_addr16;
  assign w_addr16  = 16'(w_addr_eff);
  assign w_beq_imm = in_imm - (w_addr16 + 16'd1);
`else
  assign w_beq_imm = in_imm;
`endif

  always_comb begin
    w_word = 32'h0000_0000;
    case (in_kind)
      K_NOP:   w_word = 32'h0000_0000;
      K_ADD:   w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_ADD};
      K_SUB:   w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SUB};
      K_AND:   w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_AND};
      K_OR:    w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_OR};
      K_SLT:   w_word = {OP_RTYPE, in_rs, in_rt, in_rd, 5'b0, FN_SLT};
      K_ADDI:  w_word = {OP_ADDI, in_rs, in_rt, in_imm};
      K_LW:    w_word = {OP_LW, in_rs, in_rt, in_imm};
      K_SW:    w_word = {OP_SW, in_rs, in_rt, in_imm};
      K_BEQ:   w_word = {OP_BEQ, in_rs, in_rt, w_beq_imm};
      default: w_word = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept && w_kind_ok) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_word;
      r_out_addr  <= w_addr_eff;
      r_out_last  <= in_last;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= LP_BASE;
    end else if (w_accept && in_last) begin
      r_addr <= LP_BASE;
    end else if (w_accept && w_kind_ok) begin
      r_addr <= w_addr_eff + ADDR_WIDTH'(1);
    end else begin
      r_addr <= w_addr_eff;
    end
  end

  // err_kind keeps the first offending kind; a same-edge clr counts as clearing first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err      <= 1'b0;
      r_err_kind <= '0;
    end else begin
      if (clr) begin
        r_err      <= 1'b0;
        r_err_kind <= '0;
      end
      if (w_accept && !w_kind_ok) begin
        r_err <= 1'b1;
        if (!w_err_eff) r_err_kind <= in_kind;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_addr  = r_out_addr;
  assign out_last  = r_out_last;
  assign err       = r_err;
  assign err_kind  = r_err_kind;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a reference model queues expected words, a monitor checks them.
module tb_instr_encoder;
  localparam int AW   = 3;
  localparam int BASE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rs = '0;
  logic [4:0]    in_rt = '0;
  logic [4:0]    in_rd = '0;
  logic [15:0]   in_imm = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_word;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          err;
  logic [3:0]    err_kind;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .out_last(out_last), .err(err), .err_kind(err_kind)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
    logic          l;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int         m_addr = BASE;
  bit         m_ov = 1'b0;
  bit         m_err = 1'b0;
  logic [3:0] m_ek = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [15:0] imm, input int addr);
    logic [15:0] off;
`ifdef ENCODER_BRANCH_ABS_EN
    off = imm - 16'((addr + 1) % 65536);
`else
    off = imm;
`endif
    case (k)
      4'd1: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      4'd2: return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      4'd3: return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      4'd4: return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4'd5: return {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      4'd6: return {6'h08, rs, rt, imm};
      4'd7: return {6'h23, rs, rt, imm};
      4'd8: return {6'h2B, rs, rt, imm};
      4'd9: return {6'h04, rs, rt, off};
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: evaluated mid-cycle with the inputs that the next rising edge will see
  always @(negedge clk) begin
    bit acc;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_ov || out_ready)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_kind", {28'd0, err_kind}, {28'd0, m_ek});
    if (rst) begin
      m_ov = 1'b0; m_addr = BASE; m_err = 1'b0; m_ek = '0;
      sb.delete();
    end else begin
      if (clr) begin
        m_addr = BASE; m_err = 1'b0; m_ek = '0;
      end
      acc = in_valid && (!m_ov || out_ready);
      if (acc && in_kind <= 4'd9) begin
        sb.push_back('{w: enc(in_kind, in_rs, in_rt, in_rd, in_imm, m_addr), a: AW'(m_addr), l: in_last});
        m_ov   = 1'b1;
        m_addr = (m_addr + 1) % (1 << AW);
      end else begin
        if (acc) begin
          if (!m_err) m_ek = in_kind;
          m_err = 1'b1;
        end
        if (m_ov && out_ready) m_ov = 1'b0;
      end
      if (acc && in_last) m_addr = BASE;
    end
  end

  // Monitor: the presented word must match the queue head every cycle; pop on transfer
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", out_word, 32'hDEAD_BEEF);
      end else begin
        chk("out_word", out_word, sb[0].w);
        chk("out_addr", {{(32-AW){1'b0}}, out_addr}, {{(32-AW){1'b0}}, sb[0].a});
        chk("out_last", {31'd0, out_last}, {31'd0, sb[0].l});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                     input logic [15:0] imm, input logic last);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    step(); step();
    rst = 1'b0;
    chk("rst_out_word", out_word, 32'h0);
    chk("rst_out_addr", {{(32-AW){1'b0}}, out_addr}, 32'h0);
    chk("rst_out_last", {31'd0, out_last}, 32'h0);
    out_ready = 1'b1;

    req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    req(4'd6, 5'd0, 5'd8, 5'd0, 16'd5, 1'b0);
    req(4'd7, 5'd29, 5'd9, 5'd0, 16'd4, 1'b0);
    req(4'd8, 5'd29, 5'd9, 5'd0, 16'd8, 1'b0);
    step();

    // backpressure with a request waiting
    req(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_kind = 4'd3; in_rs = 5'd7; in_rt = 5'd8; in_rd = 5'd9;
    step(); step(); step();
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();

    req(4'd12, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    req(4'd0, 5'd3, 5'd3, 5'd3, 16'h1234, 1'b1);
    req(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
    req(4'd14, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0);
    clr = 1'b1; step(); clr = 1'b0;

    req(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b0);
    req(4'd9, 5'd1, 5'd2, 5'd0, 16'd3, 1'b0);
    for (int i = 0; i < 10; i++) req(4'd1, 5'(i), 5'd2, 5'd3, 16'h0, 1'b0);

    // reset with a word pending
    out_ready = 1'b0;
    req(4'd4, 5'd1, 5'd1, 5'd1, 16'h0, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    req(4'd5, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0);
    step();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_kind   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_imm    = 16'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      clr       = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0; clr = 1'b0; rst = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encodes abstract instruction requests (kind plus register and immediate fields) into 32-bit MIPS machine words. This is the inverse of the control decoder: it produces exactly the opcode/funct combinations that the decoder accepts. It sits between the testbench/program-loader front end and instruction memory, emitting one word per accepted request, tagged with a sequential word address.
- Valid/ready on both sides.
- Single output register stage.

Parameters:
ADDR_WIDTH, 8, width of the word-address counter and out_addr (legal range 1..16)
BASE_ADDR, 0, word address given to the first instruction after reset, clr, or an accepted last

Ports:
clk  input  1  clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
clr  input  1  synchronous clear of the address counter and error state; does not flush the output register
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid && in_ready
in_kind  input  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 SLT, 6 ADDI, 7 LW, 8 SW, 9 BEQ; 10-15 invalid
in_rs  input  5  source register rs
in_rt  input  5  rt register (destination for ADDI/LW)
in_rd  input  5  destination register rd (R-type only)
in_imm  input  16  immediate / branch offset
in_last  input  1  marks the final instruction of a program
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts the word when out_valid && out_ready
out_word  output  32  encoded instruction
out_addr  output  ADDR_WIDTH  word address of out_word
out_last  output  1  copy of in_last for this word
err  output  1  sticky flag: an invalid kind was received
err_kind  output  4  in_kind of the first invalid request since reset/clr

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_word=0, out_addr=0, out_last=0.
  - err=0, err_kind=0.
  - Address counter = BASE_ADDR.
  - rst has priority over clr and over any handshake.
- Ready rule: in_ready = !out_valid || out_ready (combinational). No other combinational input-to-output paths.
- Field layouts (opcode/funct values from defines.vh):
  - R-type (ADD/SUB/AND/OR/SLT): word = {6'h00, rs, rt, rd, 5'b0, funct}, with funct 0x20/0x22/0x24/0x25/0x2A.
  - NOP: word = 32'h00000000; rs/rt/rd/imm are ignored.
  - I-type: word = {opcode, rs, rt, imm}, with ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04. The immediate is passed through unmodified (sign handling belongs to the datapath).
- Accepted valid kind:
  - Next edge: out_valid=1, out_word=encoding, out_addr=counter, out_last=in_last.
  - Counter increments by 1, wrapping modulo 2^ADDR_WIDTH. Wrap is silent.
  - Latency is 1 cycle.
- Accepted invalid kind (10-15):
  - The request is consumed but no word is emitted.
  - The output register updates only by the normal drain rule; the counter is unchanged.
  - err is set to 1. err_kind is captured only if err was 0.
  - If in_last=1 on an invalid request, the counter still returns to BASE_ADDR.
- After an accepted request with in_last=1, the counter loads BASE_ADDR instead of incrementing.
- Output drain: out_valid falls to 0 on an edge where out_valid && out_ready and no new valid request is accepted. A simultaneous drain and accept loads the new word: full throughput, 1 word/cycle.
- Backpressure: while out_valid && !out_ready, all out_* signals hold stable and in_ready=0.
- clr (without rst):
  - Counter = BASE_ADDR, err=0, err_kind=0.
  - A request accepted on the same edge uses the post-clear address, i.e. out_addr=BASE_ADDR.
  - A pending output word is kept.
- Mid-stream reset drops any pending word; the downstream side must tolerate loss.

Optional Feature:
Macro ENCODER_BRANCH_ABS_EN.
- Defined: for BEQ, in_imm is an absolute target word address. The encoder emits offset = in_imm - (counter + 1), computed modulo 2^16 with the counter zero-extended to 16 bits. All other kinds are unchanged.
- Undefined: BEQ in_imm is used verbatim as the relative offset. No subtractor is built.

Test Plan:
- After rst, send ADD rs=1 rt=2 rd=3 with out_ready=1 -> out_word=0x00221820, out_addr=0, out_valid=1 next cycle, in_ready stays 1.
- Back-to-back ADDI rt=8 rs=0 imm=5; LW rt=9 rs=29 imm=4; SW rt=9 rs=29 imm=8 -> 0x20080005 @0, 0x8FA90004 @1, 0xAFA90008 @2 on consecutive cycles.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_word/out_addr stable. Release -> next word is emitted without loss or duplication.
- in_kind=12, then NOP with in_last=1, then ADD -> err=1, err_kind=12; NOP emits 0x00000000 at addr 0; ADD is emitted at addr BASE_ADDR (0); clr -> err=0.
- BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF. With ENCODER_BRANCH_ABS_EN, BEQ at addr 5 with imm=3 -> 0x1022FFFD.
- ADDR_WIDTH=2: issue 5 ADDs -> addresses 0,1,2,3,0. Assert rst while out_valid=1 -> out_valid=0, next accepted word is at addr 0.
